// File: rtl/fifo_fwft.sv
// fifo_fwft: first-word-fall-through FIFO with registered output stage, occupancy count, almost flags and flush
module fifo_fwft #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8,
    parameter int AF_THRESH  = DEPTH - 1,
    parameter int AE_THRESH  = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic [DATA_WIDTH-1:0]      data_in,
    input  logic                       data_in_valid,
    output logic                       data_in_ready,
    output logic [DATA_WIDTH-1:0]      data_out,
    output logic                       data_out_valid,
    input  logic                       data_out_ready,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       almost_full,
    output logic                       almost_empty
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int RD = DEPTH - 1;
    localparam int PW = RD > 1 ? $clog2(RD) : 1;
    logic [DATA_WIDTH-1:0] mem [RD];
    logic [PW-1:0] wptr, rptr;
    logic w_en, r_en, load, ram_empty, ram_wr;
    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return p == PW'(RD - 1) ? '0 : p + 1'b1;
    endfunction
    assign data_in_ready = rst && (count != CW'(DEPTH));
    assign w_en          = data_in_valid && data_in_ready;
    assign r_en          = data_out_valid && data_out_ready;
    assign load          = !data_out_valid || r_en;
    // RAM holds everything except the word sitting in the output register
    assign ram_empty     = count == CW'(data_out_valid);
    assign ram_wr        = w_en && !(load && ram_empty);
    assign almost_full   = count >= CW'(AF_THRESH);
    assign almost_empty  = count <= CW'(AE_THRESH);
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            count          <= '0;
            wptr           <= '0;
            rptr           <= '0;
            data_out       <= '0;
            data_out_valid <= 1'b0;
        end else if (flush) begin
            count          <= '0;
            wptr           <= '0;
            rptr           <= '0;
            data_out_valid <= 1'b0;
        end else begin
            count <= count + CW'(w_en) - CW'(r_en);
            if (ram_wr)
                wptr <= nxt(wptr);
            if (load) begin
                data_out_valid <= !ram_empty || w_en;
                if (!ram_empty) begin
                    data_out <= mem[rptr];
                    rptr     <= nxt(rptr);
                end else if (w_en)
                    data_out <= data_in;
            end
        end
    always_ff @(posedge clk)
        if (ram_wr)
            mem[wptr] <= data_in;
endmodule

// File: tb/tb_fifo_fwft.sv
// tb_fifo_fwft: vector table, directed corner sequences and random traffic against a queue model (DEPTH 8 and 5)
module tb_fifo_fwft;
    logic clk = 0, rst = 1, flush = 0, in_valid = 0, out_ready = 0;
    logic [7:0] din = 0;
    logic [7:0] dout_a, dout_b;
    logic ov_a, ov_b, ir_a, ir_b, af_a, af_b, ae_a, ae_b;
    logic [3:0] cnt_a;
    logic [2:0] cnt_b;
    int n_checks = 0, n_err = 0;
    logic [7:0] qa[$], qb[$];
    logic [7:0] last_a = 0, last_b = 0;

    typedef struct {
        bit v; logic [7:0] d; bit r; bit f;
        int cnt; bit ov; logic [7:0] dout; bit irdy; bit af; bit ae;
    } vec_t;
    vec_t tbl[17];

    always #5 clk = ~clk;

    fifo_fwft #(.DATA_WIDTH(8), .DEPTH(8)) dut_a (
        .clk(clk), .rst(rst), .flush(flush), .data_in(din), .data_in_valid(in_valid),
        .data_in_ready(ir_a), .data_out(dout_a), .data_out_valid(ov_a), .data_out_ready(out_ready),
        .count(cnt_a), .almost_full(af_a), .almost_empty(ae_a));

    fifo_fwft #(.DATA_WIDTH(8), .DEPTH(5), .AF_THRESH(3), .AE_THRESH(1)) dut_b (
        .clk(clk), .rst(rst), .flush(flush), .data_in(din), .data_in_valid(in_valid),
        .data_in_ready(ir_b), .data_out(dout_b), .data_out_valid(ov_b), .data_out_ready(out_ready),
        .count(cnt_b), .almost_full(af_b), .almost_empty(ae_b));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: a queue of accepted words; the head is what the consumer sees.
    always @(posedge clk or negedge rst) begin
        bit wa, wb;
        if (!rst) begin
            qa.delete(); qb.delete();
            last_a <= 0; last_b <= 0;
        end else if (flush) begin
            qa.delete(); qb.delete();
        end else begin
            wa = in_valid && qa.size() < 8;
            wb = in_valid && qb.size() < 5;
            if (out_ready && qa.size() > 0) void'(qa.pop_front());
            if (out_ready && qb.size() > 0) void'(qb.pop_front());
            if (wa) qa.push_back(din);
            if (wb) qb.push_back(din);
            if (qa.size() > 0) last_a <= qa[0];
            if (qb.size() > 0) last_b <= qb[0];
        end
    end

    always @(negedge clk) begin
        chk("a_count", cnt_a, qa.size());
        chk("a_valid", ov_a, qa.size() > 0);
        chk("a_data", dout_a, last_a);
        chk("a_ready", ir_a, rst && qa.size() != 8);
        chk("a_af", af_a, qa.size() >= 7);
        chk("a_ae", ae_a, qa.size() <= 1);
        chk("b_count", cnt_b, qb.size());
        chk("b_valid", ov_b, qb.size() > 0);
        chk("b_data", dout_b, last_b);
        chk("b_ready", ir_b, rst && qb.size() != 5);
        chk("b_af", af_b, qb.size() >= 3);
        chk("b_ae", ae_b, qb.size() <= 1);
    end

    function automatic vec_t mk(bit v, logic [7:0] d, bit r, bit f, int cnt, bit ov,
                                logic [7:0] dout, bit irdy, bit af, bit ae);
        vec_t t;
        t.v = v; t.d = d; t.r = r; t.f = f; t.cnt = cnt; t.ov = ov;
        t.dout = dout; t.irdy = irdy; t.af = af; t.ae = ae;
        return t;
    endfunction

    task automatic apply(input bit v, input logic [7:0] d, input bit r, input bit f);
        @(negedge clk);
        in_valid = v; din = d; out_ready = r; flush = f;
    endtask

    task automatic step(input bit v, input logic [7:0] d, input bit r, input bit f);
        apply(v, d, r, f);
        @(posedge clk);
        #1;
    endtask

    initial begin
        tbl[0]  = mk(1, 8'h01, 0, 0, 1, 1, 8'h01, 1, 0, 1);
        tbl[1]  = mk(1, 8'h02, 0, 0, 2, 1, 8'h01, 1, 0, 0);
        tbl[2]  = mk(1, 8'h03, 0, 0, 3, 1, 8'h01, 1, 0, 0);
        tbl[3]  = mk(1, 8'h04, 0, 0, 4, 1, 8'h01, 1, 0, 0);
        tbl[4]  = mk(1, 8'h05, 0, 0, 5, 1, 8'h01, 1, 0, 0);
        tbl[5]  = mk(1, 8'h06, 0, 0, 6, 1, 8'h01, 1, 0, 0);
        tbl[6]  = mk(1, 8'h07, 0, 0, 7, 1, 8'h01, 1, 1, 0);
        tbl[7]  = mk(1, 8'h08, 0, 0, 8, 1, 8'h01, 0, 1, 0);
        tbl[8]  = mk(1, 8'h09, 0, 0, 8, 1, 8'h01, 0, 1, 0);
        tbl[9]  = mk(0, 8'h00, 1, 0, 7, 1, 8'h02, 1, 1, 0);
        tbl[10] = mk(0, 8'h00, 1, 0, 6, 1, 8'h03, 1, 0, 0);
        tbl[11] = mk(0, 8'h00, 1, 0, 5, 1, 8'h04, 1, 0, 0);
        tbl[12] = mk(0, 8'h00, 1, 0, 4, 1, 8'h05, 1, 0, 0);
        tbl[13] = mk(0, 8'h00, 1, 0, 3, 1, 8'h06, 1, 0, 0);
        tbl[14] = mk(0, 8'h00, 1, 0, 2, 1, 8'h07, 1, 0, 0);
        tbl[15] = mk(0, 8'h00, 1, 0, 1, 1, 8'h08, 1, 0, 1);
        tbl[16] = mk(0, 8'h00, 1, 0, 0, 0, 8'h08, 1, 0, 1);

        #1 rst = 0;
        @(negedge clk);
        #2;
        chk("rst_ready", ir_a, 0);
        chk("rst_count", cnt_a, 0);
        chk("rst_valid", ov_a, 0);
        chk("rst_data", dout_a, 0);
        chk("rst_af", af_a, 0);
        chk("rst_ae", ae_a, 1);
        rst = 1;
        #1 chk("ready_after_rst", ir_a, 1);

        for (int i = 0; i < 17; i++) begin
            step(tbl[i].v, tbl[i].d, tbl[i].r, tbl[i].f);
            chk("tbl_count", cnt_a, tbl[i].cnt);
            chk("tbl_valid", ov_a, tbl[i].ov);
            chk("tbl_data", dout_a, tbl[i].dout);
            chk("tbl_ready", ir_a, tbl[i].irdy);
            chk("tbl_af", af_a, tbl[i].af);
            chk("tbl_ae", ae_a, tbl[i].ae);
        end

        for (int k = 0; k < 50; k++) begin
            step(1, 8'(8'h10 + k), 1, 0);
            chk("stream_data", dout_a, 8'(8'h10 + k));
            chk("stream_count", cnt_a, 1);
            chk("stream_valid", ov_a, 1);
        end
        step(0, 8'h00, 1, 0);
        chk("stream_end_count", cnt_a, 0);
        chk("stream_end_valid", ov_a, 0);

        for (int i = 1; i <= 8; i++) step(1, 8'(i), 0, 0);
        chk("full_count", cnt_a, 8);
        chk("b_full_count", cnt_b, 5);
        chk("b_full_af", af_b, 1);
        chk("b_full_ready", ir_b, 0);
        step(1, 8'h99, 1, 0);
        chk("full_rw_count", cnt_a, 7);
        chk("full_rw_data", dout_a, 8'h02);
        chk("full_rw_ready", ir_a, 1);
        chk("b_full_rw_count", cnt_b, 4);
        step(0, 8'h00, 0, 1);
        chk("flush_count", cnt_a, 0);
        step(1, 8'h55, 0, 0);
        chk("empty_w_count", cnt_a, 1);
        chk("empty_w_valid", ov_a, 1);
        chk("empty_w_data", dout_a, 8'h55);

        for (int i = 0; i < 4; i++) step(1, 8'(8'h60 + i), 0, 0);
        chk("pre_flush_count", cnt_a, 5);
        step(1, 8'h77, 1, 1);
        chk("flush_mid_count", cnt_a, 0);
        chk("flush_mid_valid", ov_a, 0);
        chk("flush_mid_data", dout_a, 8'h55);
        step(1, 8'hAA, 0, 0);
        chk("after_flush_data", dout_a, 8'hAA);
        chk("after_flush_count", cnt_a, 1);
        step(1, 8'hBB, 1, 0);
        chk("after_flush_next", dout_a, 8'hBB);
        step(0, 8'h00, 1, 0);

        for (int i = 0; i < 4; i++) step(1, 8'(8'h31 + i), 0, 0);
        chk("pre_rst_count", cnt_a, 4);
        apply(0, 8'h00, 0, 0);
        @(posedge clk);
        #2 rst = 0;
        #1;
        chk("async_rst_count", cnt_a, 0);
        chk("async_rst_valid", ov_a, 0);
        chk("async_rst_ready", ir_a, 0);
        chk("async_rst_data", dout_a, 0);
        chk("b_async_rst_count", cnt_b, 0);
        @(negedge clk);
        #2 rst = 1;
        #1 chk("rst_release_ready", ir_a, 1);

        for (int c = 0; c < 1200; c++) begin
            bit fill_phase;
            fill_phase = ((c / 64) % 2) == 0;
            apply($urandom_range(3, 0) != 0, 8'($urandom),
                  fill_phase ? $urandom_range(3, 0) == 0 : $urandom_range(3, 0) != 0,
                  $urandom_range(79, 0) == 0);
            @(posedge clk);
        end
        apply(0, 8'h00, 0, 0);
        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
